nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 193 +++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-precision adder controller built around one 4-bit carry-look-ahead
// stage. A WIDTH-bit addition is performed one nibble per clock, least
// significant nibble first, with the inter-nibble carry held in a register.
// The result appears WIDTH/4 edges after the accepting edge.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request, sampled only while ready=1
//   A      in   WIDTH  operand A, latched on the accepting edge
//   B      in   WIDTH  operand B, latched on the accepting edge
//   CIN    in   1      carry-in, latched on the accepting edge
//   ready  out  1      a start will be accepted (IDLE or DONE)
//   busy   out  1      nibble steps in progress (ADD)
//   done   out  1      one-cycle pulse, SUM/COUT/OVF just updated
//   SUM    out  WIDTH  registered result
//   COUT   out  1      registered carry-out of the MSB nibble
//   OVF    out  1      registered two's-complement overflow
//
// WIDTH must be a multiple of 4 and at least 4.
// -----------------------------------------------------------------------------

// 4-bit carry-look-ahead adder stage: SUM/COUT = A + B + CIN.
module carry_look_ahead (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN,
    output logic [3:0] SUM,
    output logic       COUT
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is a flat function of generate/propagate and CIN.
    assign w_c[0] = CIN;
    assign w_c[1] = w_g[0] | (w_p[0] & CIN);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & CIN);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & CIN);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & CIN);

    assign SUM  = w_p ^ w_c[3:0];
    assign COUT = w_c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shadow;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_cla_sum;
    logic             w_cla_cout;
    logic [WIDTH-1:0] w_shadow_next;

    assign ready    = (r_state == IDLE) || (r_state == DONE);
    assign busy     = (r_state == ADD);
    assign w_accept = start && ready;
    assign w_last   = (r_state == ADD) && (r_idx == LAST_IDX);

    // Select the current nibble of the latched operands and merge the CLA
    // result into the shadow copy. A compare-per-nibble mux keeps every
    // slice constant, so no part-select can leave the operand range.
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that skips an assignment would otherwise infer a latch.
    always_comb begin
        w_a_nib       = 4'h0;
        w_b_nib       = 4'h0;
        w_shadow_next = r_shadow;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_nib                  = r_a[4*i +: 4];
                w_b_nib                  = r_b[4*i +: 4];
                w_shadow_next[4*i +: 4]  = w_cla_sum;
            end
        end
    end

    carry_look_ahead u_cla (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .CIN  (r_carry),
        .SUM  (w_cla_sum),
        .COUT (w_cla_cout)
    );

    // Next-state decode. start during ADD is deliberately not looked at.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = ADD;
            ADD:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? ADD : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the operand and shadow registers are plain flops, not a memory
    // array, so they are cleared with everything else; this also guarantees
    // an aborted operation leaves no stale data anywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= A;
                r_b     <= B;
                r_carry <= CIN;
                r_idx   <= '0;
            end else if (r_state == ADD) begin
                r_shadow <= w_shadow_next;
                r_carry  <= w_cla_cout;
                r_idx    <= w_last ? '0 : r_idx + IDX_W'(1);
                if (w_last) begin
                    // Results are published only here, with the final nibble
                    // taken straight from the CLA rather than the shadow.
                    r_sum  <= w_shadow_next;
                    r_cout <= w_cla_cout;
                    r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                              (w_shadow_next[WIDTH-1] != r_a[WIDTH-1]);
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign SUM  = r_sum;
    assign COUT = r_cout;
    assign OVF  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Drives three instances of nibble_serial_adder (WIDTH = 16, 8, 4) from one
// clock and shared reset. Directed vectors with hand-computed results, a few
// hand-written multi-cycle sequences (back-to-back, reset abort), and a
// random regression checked against a small arithmetic model.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH = 16 instance
    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    // WIDTH = 8 instance
    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    // WIDTH = 4 instance
    logic        start4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        ready4, busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .CIN(cin16),
        .ready(ready16), .busy(busy16), .done(done16),
        .SUM(sum16), .COUT(cout16), .OVF(ovf16)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .CIN(cin8),
        .ready(ready8), .busy(busy8), .done(done8),
        .SUM(sum8), .COUT(cout8), .OVF(ovf8)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .CIN(cin4),
        .ready(ready4), .busy(busy4), .done(done4),
        .SUM(sum4), .COUT(cout4), .OVF(ovf4)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    function automatic logic get_done(input int w);
        case (w)
            16:      return done16;
            8:       return done8;
            default: return done4;
        endcase
    endfunction

    function automatic logic get_busy_not_ready(input int w);
        case (w)
            16:      return busy16 && !ready16;
            8:       return busy8 && !ready8;
            default: return busy4 && !ready4;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            16:      start16 = v;
            8:       start8  = v;
            default: start4  = v;
        endcase
    endtask

    // Issue one operation on the selected instance and wait for its done.
    // lat = edges from the accepting edge to the edge that raised done
    // (0 on timeout); bcnt = sampled cycles with busy=1 and ready=0.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, output logic [15:0] sum,
                          output logic cout, output logic ovf,
                          output int lat, output int bcnt);
        @(negedge clk);
        case (w)
            16:      begin a16 = a;      b16 = b;      cin16 = cin; end
            8:       begin a8 = a[7:0];  b8 = b[7:0];  cin8  = cin; end
            default: begin a4 = a[3:0];  b4 = b[3:0];  cin4  = cin; end
        endcase
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        lat  = 0;
        bcnt = 0;
        if (get_busy_not_ready(w)) bcnt++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (get_done(w)) begin
                lat = i;
                break;
            end
            if (get_busy_not_ready(w)) bcnt++;
        end
        case (w)
            16:      begin sum = sum16;          cout = cout16; ovf = ovf16; end
            8:       begin sum = {8'h0, sum8};   cout = cout8;  ovf = ovf8;  end
            default: begin sum = {12'h0, sum4};  cout = cout4;  ovf = ovf4;  end
        endcase
    endtask

    // Reference arithmetic: {cout,sum} = a + b + cin over w bits.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output logic [15:0] sum,
                         output logic cout, output logic ovf);
        logic [31:0] full;
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        full = (32'(a) & mask) + (32'(b) & mask) + 32'(cin);
        sum  = 16'(full & mask);
        cout = full[w];
        ovf  = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [15:0] s, es;
        logic        c, o, ec, eo;
        int          lat, bcnt, seen;

        vecs[0] = '{16'h000B, 16'h0006, 1'b0, 16'h0011, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready16", ready16, 1'b1);
        check("rst_busy16",  busy16,  1'b0);
        check("rst_done16",  done16,  1'b0);
        check("rst_res16",   {cout16, ovf16, sum16}, 18'h0);
        check("rst_ready4",  ready4,  1'b1);
        check("rst_res4",    {done4, cout4, ovf4, sum4}, 7'h0);

        // ---------------- directed table, WIDTH=16 ----------------
        foreach (vecs[k]) begin
            run_op(16, vecs[k].a, vecs[k].b, vecs[k].cin, s, c, o, lat, bcnt);
            check($sformatf("vec%0d_lat", k),  lat, 4);
            check($sformatf("vec%0d_busy", k), bcnt, 4);
            check($sformatf("vec%0d_res", k), {c, o, s},
                  {vecs[k].cout, vecs[k].ovf, vecs[k].sum});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", k), done16, 1'b0);
            check($sformatf("vec%0d_hold", k), {ready16, cout16, ovf16, sum16},
                  {1'b1, vecs[k].cout, vecs[k].ovf, vecs[k].sum});
        end

        // ---------------- back-to-back with start held high ----------------
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1;
        a16 = 16'hFFFF; b16 = 16'h0001;       // ignored: op already latched
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done16) begin lat = i; break; end
        end
        check("b2b_lat1", lat, 4);
        check("b2b_sum1", {cout16, sum16}, {1'b0, 16'h2345});
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start16 = 1'b0;       // second op accepted from DONE
            if (done16) begin lat = i; break; end
        end
        check("b2b_gap", lat, 5);
        check("b2b_sum2", {cout16, ovf16, sum16}, {1'b1, 1'b0, 16'h0000});
        @(posedge clk);
        #1;
        check("b2b_idle", {ready16, busy16, done16}, 3'b100);

        // ---------------- reset abort mid-ADD ----------------
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_before", busy16, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_state", {ready16, busy16, done16}, 3'b100);
        check("abort_res", {cout16, ovf16, sum16}, 18'h0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done16) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_res_hold", {ready16, cout16, ovf16, sum16}, {1'b1, 18'h0});
        run_op(16, 16'h000B, 16'h0006, 1'b0, s, c, o, lat, bcnt);
        check("post_abort_lat", lat, 4);
        check("post_abort_res", {c, o, s}, {1'b0, 1'b0, 16'h0011});

        // ---------------- WIDTH=4 ----------------
        run_op(4, 16'hA, 16'hA, 1'b1, s, c, o, lat, bcnt);
        check("w4_lat1", lat, 1);
        check("w4_res1", {c, o, s[3:0]}, {1'b1, 1'b1, 4'h5});
        @(posedge clk);
        #1;
        check("w4_done_pulse", done4, 1'b0);
        run_op(4, 16'hB, 16'h6, 1'b0, s, c, o, lat, bcnt);
        check("w4_lat2", lat, 1);
        check("w4_res2", {c, o, s[3:0]}, {1'b1, 1'b0, 4'h1});

        // ---------------- WIDTH=8 directed ----------------
        run_op(8, 16'h7F, 16'h01, 1'b0, s, c, o, lat, bcnt);
        check("w8_lat", lat, 2);
        check("w8_res", {c, o, s[7:0]}, {1'b0, 1'b1, 8'h80});

        // ---------------- random regression ----------------
        for (int wsel = 0; wsel < 2; wsel++) begin
            int          w;
            logic [15:0] ra, rb;
            logic        rc;
            w = (wsel == 0) ? 16 : 8;
            for (int n = 0; n < 1000; n++) begin
                int gap;
                ra  = 16'($urandom);
                rb  = 16'($urandom);
                rc  = 1'($urandom);
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    if (get_done(w)) check($sformatf("rand%0d_gap_done", w), 1'b1, 1'b0);
                end
                run_op(w, ra, rb, rc, s, c, o, lat, bcnt);
                model(w, ra, rb, rc, es, ec, eo);
                check($sformatf("rand%0d_lat", w), lat, w / 4);
                check($sformatf("rand%0d_res", w), {c, o, s}, {ec, eo, es});
            end
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
